// File: rtl/gpr_file_mp_if.sv
// Bus bundle for gpr_file_mp: one byte-enabled write port, packed read ports, debug read and busy.
interface gpr_file_mp_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_READ   = 2
);
  logic                           wr_en;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic [DATA_WIDTH/8-1:0]        wr_be;
  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0]          dbg_addr;
  logic [DATA_WIDTH-1:0]          dbg_data;
  logic                           busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_addr, dbg_addr,
    input  rd_data, dbg_data, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_addr, dbg_addr,
    output rd_data, dbg_data, busy
  );
endinterface

// File: rtl/gpr_file_mp.sv
// Multi-port register file with hard-wired zero register, optional write bypass
// and a post-reset clear sequencer so the array needs no bulk reset.
module gpr_file_mp #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic          clk,
  input  logic          reset,
  gpr_file_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LANES = DATA_WIDTH / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [1:DEPTH-1];
  logic                    clearing;
  logic                    wr_hit;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data_c;
  logic [DATA_WIDTH-1:0]   dbg_data_c;

  assign clearing = (state == CLEAR);
  assign wr_hit   = (state == READY) && bus.wr_en && (bus.wr_addr != '0);

  // Clear sequencer: walks entries 1..DEPTH-1 once after every reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= ADDR_WIDTH'(1);
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
        state <= READY;
      end
    end
  end

  // Array update; the reset edge itself leaves contents alone
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (wr_hit) begin
        for (int i = 0; i < LANES; i++) begin
          if (bus.wr_be[i]) begin
            mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
          end
        end
      end
    end
  end

  // Read ports resolve independently; each may pick up the in-flight write lanes
  always_comb begin : rd_mux
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] word;
    rd_data_c = '0;
    ra        = '0;
    word      = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      ra   = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      word = '0;
      if (!clearing && (ra != '0)) begin
        word = mem[ra];
        if ((BYPASS != 0) && wr_hit && (ra == bus.wr_addr)) begin
          for (int i = 0; i < LANES; i++) begin
            if (bus.wr_be[i]) begin
              word[8*i +: 8] = bus.wr_data[8*i +: 8];
            end
          end
        end
      end
      rd_data_c[p*DATA_WIDTH +: DATA_WIDTH] = word;
    end
  end

  // Debug port always shows stored contents
  always_comb begin
    dbg_data_c = '0;
    if (!clearing && (bus.dbg_addr != '0)) begin
      dbg_data_c = mem[bus.dbg_addr];
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.dbg_data = dbg_data_c;
  assign bus.busy     = clearing;

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench for gpr_file_mp: bypass and non-bypass 5x32x2 instances plus a 3x16x4 instance.
module tb_gpr_file_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gpr_file_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2)) b1_if ();
  gpr_file_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2)) b0_if ();
  gpr_file_mp_if #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .NUM_READ(4)) sm_if ();

  gpr_file_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .BYPASS(1)) dut_b1 (
    .clk(clk), .reset(reset), .bus(b1_if.slave));
  gpr_file_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .BYPASS(0)) dut_b0 (
    .clk(clk), .reset(reset), .bus(b0_if.slave));
  gpr_file_mp #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .NUM_READ(4), .BYPASS(1)) dut_sm (
    .clk(clk), .reset(reset), .bus(sm_if.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_big(input logic en, input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    b1_if.wr_en = en; b1_if.wr_addr = a; b1_if.wr_data = d; b1_if.wr_be = be;
    b0_if.wr_en = en; b0_if.wr_addr = a; b0_if.wr_data = d; b0_if.wr_be = be;
  endtask

  task automatic read_big(input logic [4:0] r1, input logic [4:0] r0, input logic [4:0] dbg);
    b1_if.rd_addr = {r1, r0}; b1_if.dbg_addr = dbg;
    b0_if.rd_addr = {r1, r0}; b0_if.dbg_addr = dbg;
  endtask

  task automatic wr_big(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    drive_big(1'b1, a, d, be);
    step();
    drive_big(1'b0, 5'd0, 32'h0, 4'h0);
  endtask

  // Counts edges until the bypass instance drops busy; also records the small instance
  task automatic wait_clear(output int cnt, output int sm_cnt);
    cnt = 0;
    sm_cnt = 0;
    while (b1_if.busy === 1'b1 && cnt < 100) begin
      n_checks++;
      if (b1_if.rd_data !== 64'h0 || b1_if.dbg_data !== 32'h0 || b0_if.rd_data !== 64'h0) begin
        n_fail++;
        $display("FAIL busy_reads_zero cyc=%0d b1_rd=%h b1_dbg=%h b0_rd=%h expected 0", cnt,
                 b1_if.rd_data, b1_if.dbg_data, b0_if.rd_data);
      end
      step();
      cnt++;
      if (sm_if.busy !== 1'b1 && sm_cnt == 0) sm_cnt = cnt;
    end
  endtask

  task automatic test_reset();
    int cnt, sm_cnt;
    reset = 1'b1;
    step();
    n_checks++;
    if (b1_if.busy !== 1'b1 || b0_if.busy !== 1'b1 || sm_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy got %b%b%b expected 111", b1_if.busy, b0_if.busy, sm_if.busy);
    end
    step();
    step();
    reset = 1'b0;
    drive_big(1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
    read_big(5'd5, 5'd5, 5'd5);
    #1;
    wait_clear(cnt, sm_cnt);
    drive_big(1'b0, 5'd0, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (cnt != 31) begin
      n_fail++;
      $display("FAIL clear_len got %0d expected 31", cnt);
    end
    n_checks++;
    if (sm_cnt != 7) begin
      n_fail++;
      $display("FAIL clear_len_small got %0d expected 7", sm_cnt);
    end
    n_checks++;
    if (b0_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_len_nobypass busy got %b expected 0", b0_if.busy);
    end
    n_checks++;
    if (b1_if.rd_data[31:0] !== 32'h0 || b0_if.rd_data[31:0] !== 32'h0 || b1_if.dbg_data !== 32'h0) begin
      n_fail++;
      $display("FAIL dropped_write reg5 got %h/%h/%h expected 0", b1_if.rd_data[31:0],
               b0_if.rd_data[31:0], b1_if.dbg_data);
    end
  endtask

  task automatic test_byte_merge();
    wr_big(5'd3, 32'h11223344, 4'hF);
    wr_big(5'd3, 32'hAABBCCDD, 4'h5);
    read_big(5'd3, 5'd3, 5'd3);
    #1;
    n_checks++;
    if (b1_if.rd_data !== {2{32'h11BB33DD}} || b0_if.rd_data !== {2{32'h11BB33DD}}) begin
      n_fail++;
      $display("FAIL byte_merge got %h / %h expected 11BB33DD x2", b1_if.rd_data, b0_if.rd_data);
    end
  endtask

  task automatic test_bypass();
    wr_big(5'd7, 32'h0000FFFF, 4'hF);
    read_big(5'd7, 5'd7, 5'd7);
    drive_big(1'b1, 5'd7, 32'h12345678, 4'hC);
    #1;
    n_checks++;
    if (b1_if.rd_data !== {2{32'h1234FFFF}}) begin
      n_fail++;
      $display("FAIL bypass_ports got %h expected 1234FFFF x2", b1_if.rd_data);
    end
    n_checks++;
    if (b1_if.dbg_data !== 32'h0000FFFF) begin
      n_fail++;
      $display("FAIL bypass_dbg got %h expected 0000FFFF", b1_if.dbg_data);
    end
    n_checks++;
    if (b0_if.rd_data !== {2{32'h0000FFFF}}) begin
      n_fail++;
      $display("FAIL nobypass_same_cycle got %h expected 0000FFFF x2", b0_if.rd_data);
    end
    step();
    drive_big(1'b0, 5'd0, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (b0_if.rd_data !== {2{32'h1234FFFF}} || b1_if.rd_data !== {2{32'h1234FFFF}}) begin
      n_fail++;
      $display("FAIL bypass_next_cycle got %h / %h expected 1234FFFF x2", b0_if.rd_data, b1_if.rd_data);
    end
    // Bypass on one port only, other port reads an unrelated register
    read_big(5'd7, 5'd3, 5'd0);
    drive_big(1'b1, 5'd7, 32'hCAFEF00D, 4'h3);
    #1;
    n_checks++;
    if (b1_if.rd_data !== {32'h1234F00D, 32'h11BB33DD}) begin
      n_fail++;
      $display("FAIL bypass_split got %h expected 1234F00D11BB33DD", b1_if.rd_data);
    end
    drive_big(1'b0, 5'd0, 32'h0, 4'h0);
  endtask

  task automatic test_zero_reg();
    read_big(5'd0, 5'd0, 5'd0);
    drive_big(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF);
    #1;
    n_checks++;
    if (b1_if.rd_data !== 64'h0 || b0_if.rd_data !== 64'h0 || b1_if.dbg_data !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_same_cycle got %h / %h / %h expected 0", b1_if.rd_data, b0_if.rd_data,
               b1_if.dbg_data);
    end
    step();
    drive_big(1'b0, 5'd0, 32'h0, 4'h0);
    #1;
    n_checks++;
    if (b1_if.rd_data !== 64'h0 || b0_if.rd_data !== 64'h0) begin
      n_fail++;
      $display("FAIL zero_after got %h / %h expected 0", b1_if.rd_data, b0_if.rd_data);
    end
    // Empty byte enable must leave reg3 untouched
    wr_big(5'd3, 32'hFFFFFFFF, 4'h0);
    read_big(5'd0, 5'd3, 5'd3);
    #1;
    n_checks++;
    if (b1_if.rd_data[31:0] !== 32'h11BB33DD || b1_if.dbg_data !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL be_zero_noop got %h / %h expected 11BB33DD", b1_if.rd_data[31:0], b1_if.dbg_data);
    end
  endtask

  task automatic test_mid_clear();
    int cnt, sm_cnt;
    for (int a = 11; a <= 15; a++) wr_big(5'(a), 32'hA5A5A5A5, 4'hF);
    read_big(5'd15, 5'd12, 5'd11);
    #1;
    n_checks++;
    if (b1_if.rd_data !== {2{32'hA5A5A5A5}} || b1_if.dbg_data !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL preload got %h / %h expected A5A5A5A5", b1_if.rd_data, b1_if.dbg_data);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    n_checks++;
    if (b1_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_busy got %b expected 1", b1_if.busy);
    end
    reset = 1'b0;
    #1;
    wait_clear(cnt, sm_cnt);
    n_checks++;
    if (cnt != 31) begin
      n_fail++;
      $display("FAIL restart_len got %0d expected 31", cnt);
    end
    n_checks++;
    if (b1_if.rd_data !== 64'h0 || b0_if.rd_data !== 64'h0 || b1_if.dbg_data !== 32'h0) begin
      n_fail++;
      $display("FAIL restart_cleared got %h / %h / %h expected 0", b1_if.rd_data, b0_if.rd_data,
               b1_if.dbg_data);
    end
  endtask

  task automatic test_param_sweep();
    n_checks++;
    if (sm_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL small_ready busy got %b expected 0", sm_if.busy);
    end
    for (int i = 1; i <= 4; i++) begin
      sm_if.wr_en = 1'b1; sm_if.wr_addr = 3'(i); sm_if.wr_data = 16'(i * 257); sm_if.wr_be = 2'b11;
      step();
    end
    sm_if.wr_en = 1'b0;
    sm_if.rd_addr = {3'd4, 3'd3, 3'd2, 3'd1};
    sm_if.dbg_addr = 3'd4;
    #1;
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (sm_if.rd_data[p*16 +: 16] !== 16'((p + 1) * 257)) begin
        n_fail++;
        $display("FAIL sweep_port%0d got %h expected %h", p, sm_if.rd_data[p*16 +: 16],
                 16'((p + 1) * 257));
      end
    end
    n_checks++;
    if (sm_if.dbg_data !== 16'h0404) begin
      n_fail++;
      $display("FAIL sweep_dbg got %h expected 0404", sm_if.dbg_data);
    end
    // Upper-lane-only write with bypass on ports 0 and 2 (both read reg 2)
    sm_if.rd_addr = {3'd0, 3'd2, 3'd1, 3'd2};
    sm_if.wr_en = 1'b1; sm_if.wr_addr = 3'd2; sm_if.wr_data = 16'hFFFF; sm_if.wr_be = 2'b10;
    #1;
    n_checks++;
    if (sm_if.rd_data !== {16'h0000, 16'hFF02, 16'h0101, 16'hFF02}) begin
      n_fail++;
      $display("FAIL sweep_bypass got %h expected 0000FF020101FF02", sm_if.rd_data);
    end
    step();
    sm_if.wr_en = 1'b0;
    sm_if.dbg_addr = 3'd2;
    #1;
    n_checks++;
    if (sm_if.dbg_data !== 16'hFF02) begin
      n_fail++;
      $display("FAIL sweep_lane_write got %h expected FF02", sm_if.dbg_data);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive_big(1'b0, 5'd0, 32'h0, 4'h0);
    read_big(5'd0, 5'd0, 5'd0);
    sm_if.wr_en = 1'b0; sm_if.wr_addr = '0; sm_if.wr_data = '0; sm_if.wr_be = '0;
    sm_if.rd_addr = '0; sm_if.dbg_addr = '0;
    step();
    test_reset();
    test_byte_merge();
    test_bypass();
    test_zero_reg();
    test_mid_clear();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
